inst_fetch: RTL and testbench

INST_FETCH -- requirements
Module: inst_fetch

---
 rtl/inst_fetch.sv | 138 +++++++++++++
 tb/tb_inst_fetch.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch.sv
// Instruction fetch unit: fetches a word, splits it into fields, and hands it to the datapath.
// Optional one-entry prefetch buffer is enabled by defining INST_FETCH_PREFETCH_EN.
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_b,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_data,
  output logic [5:0]  opcode,
  output logic [4:0]  rs_num,
  output logic [4:0]  rt_num,
  output logic [4:0]  rd_num,
  output logic [4:0]  sh_mount,
  output logic [5:0]  func,
  output logic [15:0] imm,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] pc,
  output logic        halted
);

  typedef enum logic [1:0] {FETCH, ISSUE, HALT} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic        req_c;
  logic [31:0] addr_c;

`ifdef INST_FETCH_PREFETCH_EN
  logic        pf_valid_q, pf_valid_d;
  logic [31:0] pf_data_q, pf_data_d;
`endif

  function automatic logic is_syscall(input logic [31:0] w);
    return (w[31:26] == 6'd0) && (w[5:0] == 6'h0C);
  endfunction

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    req_c   = 1'b0;
    addr_c  = pc_q;
`ifdef INST_FETCH_PREFETCH_EN
    pf_valid_d = pf_valid_q;
    pf_data_d  = pf_data_q;
`endif
    case (state_q)
      FETCH: begin
        req_c = 1'b1;
        if (mem_ack) begin
          ir_d    = mem_data;
          state_d = is_syscall(mem_data) ? HALT : ISSUE;
        end
      end
      ISSUE: begin
`ifdef INST_FETCH_PREFETCH_EN
        if (!pf_valid_q) begin
          req_c  = 1'b1;
          addr_c = pc_q + 32'd4;
        end
        if (inst_ready) begin
          pc_d = pc_q + 32'd4;
          if (pf_valid_q) begin
            ir_d       = pf_data_q;
            pf_valid_d = 1'b0;
            state_d    = is_syscall(pf_data_q) ? HALT : ISSUE;
          end else if (mem_ack) begin
            // Prefetch ack lands on the handshake cycle: promote it straight to the IR.
            ir_d    = mem_data;
            state_d = is_syscall(mem_data) ? HALT : ISSUE;
          end else begin
            // Outstanding prefetch continues as a plain fetch at the same address.
            state_d = FETCH;
          end
        end else if (!pf_valid_q && mem_ack) begin
          pf_valid_d = 1'b1;
          pf_data_d  = mem_data;
        end
`else
        if (inst_ready) begin
          pc_d    = pc_q + 32'd4;
          state_d = FETCH;
        end
`endif
      end
      HALT:    state_d = HALT;
      default: state_d = FETCH;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q <= FETCH;
      pc_q    <= {RESET_PC[31:2], 2'b00};
      ir_q    <= '0;
`ifdef INST_FETCH_PREFETCH_EN
      pf_valid_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
`ifdef INST_FETCH_PREFETCH_EN
      pf_valid_q <= pf_valid_d;
`endif
    end
  end

`ifdef INST_FETCH_PREFETCH_EN
  // NOTE: the buffered word is only read when pf_valid_q is set, so its payload needs no reset.
  always_ff @(posedge clk) begin
    pf_data_q <= pf_data_d;
  end
`endif

  // Reset must silence the request immediately, not just at the next edge.
  assign mem_req    = req_c & rst_b;
  assign mem_addr   = addr_c;
  assign inst_valid = (state_q == ISSUE);
  assign halted     = (state_q == HALT);
  assign pc         = pc_q;

  assign opcode   = ir_q[31:26];
  assign rs_num   = ir_q[25:21];
  assign rt_num   = ir_q[20:16];
  assign rd_num   = ir_q[15:11];
  assign sh_mount = ir_q[10:6];
  assign func     = ir_q[5:0];
  assign imm      = ir_q[15:0];

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: vector table plus scoreboard of issued instructions.
// A second instance with RESET_PC=32'hFFFF_FFFC covers the wrap case.
module tb_inst_fetch;

  logic        clk = 1'b0;
  logic        rst_b;
  logic        mem_ack, inst_ready;
  logic [31:0] mem_data;

  logic        mem_req, inst_valid, halted;
  logic [31:0] mem_addr, pc;
  logic [5:0]  opcode, func;
  logic [4:0]  rs_num, rt_num, rd_num, sh_mount;
  logic [15:0] imm;

  logic        hi_mem_req, hi_inst_valid, hi_halted;
  logic [31:0] hi_mem_addr, hi_pc;
  logic [5:0]  hi_opcode, hi_func;
  logic [4:0]  hi_rs_num, hi_rt_num, hi_rd_num, hi_sh_mount;
  logic [15:0] hi_imm;

  always #5 clk = ~clk;

  inst_fetch dut (
    .clk(clk), .rst_b(rst_b), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_data(mem_data), .opcode(opcode), .rs_num(rs_num),
    .rt_num(rt_num), .rd_num(rd_num), .sh_mount(sh_mount), .func(func), .imm(imm),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .pc(pc), .halted(halted)
  );

  inst_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut_hi (
    .clk(clk), .rst_b(rst_b), .mem_req(hi_mem_req), .mem_addr(hi_mem_addr),
    .mem_ack(mem_ack), .mem_data(mem_data), .opcode(hi_opcode), .rs_num(hi_rs_num),
    .rt_num(hi_rt_num), .rd_num(hi_rd_num), .sh_mount(hi_sh_mount), .func(hi_func),
    .imm(hi_imm), .inst_valid(hi_inst_valid), .inst_ready(inst_ready), .pc(hi_pc),
    .halted(hi_halted)
  );

  typedef struct {
    logic [31:0] data;
    int          ack_dly;
    int          rdy_dly;
    bit          spur;
    logic [5:0]  op;
    logic [4:0]  rs, rt, rd, sh;
    logic [5:0]  fn;
    logic [15:0] imm;
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    vec_t        v;
  } exp_t;

  vec_t vecs[5];
  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Scoreboard: each handshake on the main instance must match the oldest pushed expectation.
  always @(negedge clk) begin
    if (rst_b && inst_valid && inst_ready) begin
      check("sb_empty_at_issue", 32'(sb.size() == 0), 32'd0);
      if (sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        check("sb_pc", pc, e.pc);
        check("sb_opcode", 32'(opcode), 32'(e.v.op));
        check("sb_rs", 32'(rs_num), 32'(e.v.rs));
        check("sb_rt", 32'(rt_num), 32'(e.v.rt));
        check("sb_rd", 32'(rd_num), 32'(e.v.rd));
        check("sb_sh", 32'(sh_mount), 32'(e.v.sh));
        check("sb_func", 32'(func), 32'(e.v.fn));
        check("sb_imm", 32'(imm), 32'(e.v.imm));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] exp_pc;
    vec_t        pv;

    //          data          ack rdy spur op     rs     rt      rd      sh      fn     imm
    vecs[0] = '{32'h012A4020, 0,  5,  0,   6'h00, 5'd9,  5'd10,  5'd8,   5'd0,   6'h20, 16'h4020};
    vecs[1] = '{32'h8D28FFFC, 3,  0,  1,   6'h23, 5'd9,  5'd8,   5'd31,  5'd31,  6'h3C, 16'hFFFC};
    vecs[2] = '{32'hFFFFFFFF, 1,  2,  0,   6'h3F, 5'd31, 5'd31,  5'd31,  5'd31,  6'h3F, 16'hFFFF};
    vecs[3] = '{32'h0000000D, 0,  0,  0,   6'h00, 5'd0,  5'd0,   5'd0,   5'd0,   6'h0D, 16'h000D};
    vecs[4] = '{32'h0400000C, 2,  1,  0,   6'h01, 5'd0,  5'd0,   5'd0,   5'd0,   6'h0C, 16'h000C};

    rst_b = 1'b0; mem_ack = 1'b0; inst_ready = 1'b0; mem_data = '0;
    #12;
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_inst_valid", 32'(inst_valid), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_pc", pc, 32'h0);
    check("rst_opcode_func", {20'd0, opcode, func}, 32'd0);
    check("rst_hi_pc", hi_pc, 32'hFFFF_FFFC);
    check("rst_hi_mem_req", 32'(hi_mem_req), 32'd0);
    @(posedge clk); #1;
    rst_b = 1'b1;
    #1;

`ifdef INST_FETCH_PREFETCH_EN
    // Back-to-back issue: ack and ready always high, fed word tracks the requested address.
    inst_ready = 1'b1;
    mem_ack    = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check("pf_mem_addr", mem_addr, 32'(4 * k));
      check("pf_mem_req", 32'(mem_req), 32'd1);
      mem_data = 32'h2000_0000 | 32'(4 * k);
      if (k < 3) begin
        pv = '{mem_data, 0, 0, 0, 6'h08, 5'd0, 5'd0, 5'd0, 5'd0, 6'(4 * k), 16'(4 * k)};
        sb.push_back('{32'(4 * k), pv});
      end
      step();
      if (k < 3) begin
        check("pf_inst_valid", 32'(inst_valid), 32'd1);
        check("pf_pc", pc, 32'(4 * k));
      end
    end
    inst_ready = 1'b0;
    mem_ack    = 1'b0;
`else
    exp_pc = 32'h0;
    foreach (vecs[i]) begin
      for (int k = 0; k <= vecs[i].ack_dly; k++) begin
        check("fetch_mem_req", 32'(mem_req), 32'd1);
        check("fetch_mem_addr", mem_addr, exp_pc);
        check("fetch_inst_valid", 32'(inst_valid), 32'd0);
        if (k == vecs[i].ack_dly) begin
          mem_ack  = 1'b1;
          mem_data = vecs[i].data;
          sb.push_back('{exp_pc, vecs[i]});
        end
        step();
      end
      mem_ack  = vecs[i].spur;
      mem_data = 32'hDEAD_BEEF;
      for (int r = 0; r <= vecs[i].rdy_dly; r++) begin
        check("issue_inst_valid", 32'(inst_valid), 32'd1);
        check("issue_mem_req", 32'(mem_req), 32'd0);
        check("issue_opcode", 32'(opcode), 32'(vecs[i].op));
        check("issue_imm", 32'(imm), 32'(vecs[i].imm));
        check("issue_pc", pc, exp_pc);
        if (r == vecs[i].rdy_dly) inst_ready = 1'b1;
        step();
        mem_ack = 1'b0;
      end
      inst_ready = 1'b0;
      exp_pc += 32'd4;
    end

    // Syscall: never issued, fetching stops until reset.
    check("sys_mem_addr", mem_addr, exp_pc);
    mem_ack  = 1'b1;
    mem_data = 32'h0000_000C;
    step();
    inst_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      check("halt_halted", 32'(halted), 32'd1);
      check("halt_inst_valid", 32'(inst_valid), 32'd0);
      check("halt_mem_req", 32'(mem_req), 32'd0);
      check("halt_pc", pc, exp_pc);
      step();
    end
    mem_ack = 1'b0; inst_ready = 1'b0;

    // Wrap from 32'hFFFF_FFFC on the high instance.
    rst_b = 1'b0;
    step();
    rst_b = 1'b1;
    #1;
    check("wrap_hi_first_addr", hi_mem_addr, 32'hFFFF_FFFC);
    check("wrap_lo_first_addr", mem_addr, 32'h0);
    check("wrap_halted_cleared", 32'(halted), 32'd0);
    mem_ack  = 1'b1;
    mem_data = vecs[0].data;
    sb.push_back('{32'h0, vecs[0]});
    step();
    mem_ack = 1'b0;
    check("wrap_hi_valid", 32'(hi_inst_valid), 32'd1);
    check("wrap_hi_pc", hi_pc, 32'hFFFF_FFFC);
    inst_ready = 1'b1;
    step();
    inst_ready = 1'b0;
    check("wrap_hi_mem_req", 32'(hi_mem_req), 32'd1);
    check("wrap_hi_next_addr", hi_mem_addr, 32'h0);
    check("wrap_lo_next_addr", mem_addr, 32'h4);

    // Reset pulse in the middle of an outstanding request; an ack during reset is dropped.
    step();
    rst_b = 1'b0;
    #1;
    check("midrst_mem_req", 32'(mem_req), 32'd0);
    check("midrst_hi_mem_req", 32'(hi_mem_req), 32'd0);
    mem_ack  = 1'b1;
    mem_data = 32'h1234_5678;
    step();
    check("midrst_pc", pc, 32'h0);
    check("midrst_hi_pc", hi_pc, 32'hFFFF_FFFC);
    check("midrst_inst_valid", 32'(inst_valid), 32'd0);
    mem_ack = 1'b0;
    rst_b   = 1'b1;
    #1;
    check("restart_mem_req", 32'(mem_req), 32'd1);
    check("restart_mem_addr", mem_addr, 32'h0);
    check("restart_hi_mem_addr", hi_mem_addr, 32'hFFFF_FFFC);
`endif

    step();
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
